qkd_gate_scheduler: RTL
=======================

# qkd_gate_scheduler

Receiver-side detection-slot controller for the QKD receiver. It sits between the raw 4-channel detector TTL inputs and the downstream sifting/logging logic. After a transmitter sync it opens a periodic gate window in every time slot and enforces detector dead time. Each slot's clicks are classified as none, single, or multi, and click results are queued in a small FIFO behind a valid/ready output.

## Interface
- `SLOT_CYCLES`, default 8: clock cycles per time slot; must be ≥ GATE_CYCLES+1.
- `GATE_CYCLES`, default 2: gate-open cycles at the start of each slot.
- `DEAD_CYCLES`, default 16: blanking cycles after any accepted click.
- `FRAME_SLOTS`, default 256: slots per frame; maximum 256.
- `FIFO_DEPTH`, default 8: result FIFO entries; power of 2.
- `clk` in, 1: single clock; all logic on its rising edge.
- `rst_n` in, 1: asynchronous active-low reset.
- `enable` in, 1: level; run when high.
- `sync_pulse` in, 1: 1-cycle frame start from the transmitter link.
- `ttl_pulses` in, 4: detector TTLs, one bit per detector (index 0..3).
- `res_valid` out, 1: FIFO head valid.
- `res_ready` in, 1: consumer accepts the head when `res_valid & res_ready`.
- `res_det` out, 2: detector index of a single click; 0 when multi.
- `res_multi` out, 1: more than one detector clicked in the slot.
- `res_slot` out, 8: slot number within the frame.
- `frame_done` out, 1: 1-cycle pulse after the last slot of a frame.
- `overflow` out, 1: sticky; a result was dropped because the FIFO was full.
- `busy` out, 1: high in WAIT_SYNC or RUN.

## Operation
- States are IDLE, WAIT_SYNC, and RUN.
  - IDLE→WAIT_SYNC when `enable`=1.
  - WAIT_SYNC→RUN on `sync_pulse`.
  - RUN→WAIT_SYNC after slot FRAME_SLOTS-1 ends.
  - Any state→IDLE when `enable`=0, taking effect on the next edge. The partial slot is discarded and FIFO contents are kept.
- `ttl_pulses` is registered once (`ttl_q`). All detection logic uses `ttl_q`.
- In RUN:
  - `phase` counts 0..SLOT_CYCLES-1 and `slot` counts 0..FRAME_SLOTS-1; both wrap.
  - Gate is open while `phase` < GATE_CYCLES and `dead_cnt` = 0.
  - Gate-open cycles OR `ttl_q` into a 4-bit `hits` accumulator.
- At `phase`=SLOT_CYCLES-1, the slot is evaluated:
  - `hits`=0: no push.
  - Exactly one bit set: push {det=index, multi=0, slot}.
  - Two or more bits set: push {det=0, multi=1, slot}.
  - If pushed, `dead_cnt` loads DEAD_CYCLES.
  - `hits` clears.
- `dead_cnt` decrements each cycle while nonzero, in all states. Clicks while dead are ignored.
- `sync_pulse` outside WAIT_SYNC is ignored.
- FIFO behaviour:
  - A push when full is dropped and sets `overflow`. Exception: the push is accepted if a pop happens in the same cycle.
  - `overflow` clears only on reset or on the `enable` 0→1 edge.
- Reset values: state IDLE, all counters and `hits` 0, FIFO empty, `res_valid`/`res_multi`/`frame_done`/`overflow`/`busy` 0, `res_det` 0, `res_slot` 0.

## Timing
- `sync_pulse` sampled at edge N → RUN with `phase`=0, `slot`=0 from edge N+1.
- TTL latency:
  - A TTL high at edge T is in `ttl_q` at T+1.
  - It counts only if the gate is open in the cycle `ttl_q` is evaluated.
- A slot-end push at edge E → `res_valid`=1 at E+1 if the FIFO was empty. The output is the registered FIFO head; there is no combinational path from `ttl_pulses`.
- `frame_done` is asserted for one cycle, coincident with the RUN→WAIT_SYNC edge.
- `res_*` are stable while `res_valid` & !`res_ready`.
- FIFO throughput is one pop per cycle.

## Structure
- Package `qkd_rx_pkg` holds:
  - state enum `sched_state_t`;
  - `det_idx_t` (2-bit);
  - `slot_result_t` struct {det, multi, slot};
  - constant `NUM_DETECTORS`=4.
- Sub-module `qkd_result_fifo` is a synchronous FIFO of `slot_result_t` with full/empty. Push/pop policy and `overflow` live in the parent.

## Test plan
- Defaults; sync, then detector 2 pulsed 1 cycle aligned with slot-3 `phase`=0 → one result {det=2, multi=0, slot=3}; no other results.
- Detectors 0 and 3 both clicking in slot 5's gate → {det=0, multi=1, slot=5}.
- Click in slot 0, then clicks in slots 1 and 2 (within DEAD_CYCLES=16) → only slot 0 reported; a click in slot 3 is reported.
- Click at `phase`=4, outside the gate, each slot → no results; `frame_done` pulses once after 256×8 cycles, then the block waits for sync.
- `res_ready`=0, clicks in 10 spaced slots → 8 results queued and `overflow`=1; drain yields slots in order; `overflow` holds until an enable toggle.
- `rst_n` low mid-frame with the FIFO non-empty → all outputs 0 immediately (asynchronous); after release the block stays in IDLE until `enable`.

Source files
------------

// File: rtl/qkd_rx_pkg.sv
// Shared types and helpers for the QKD receiver detection-slot path.
package qkd_rx_pkg;

  localparam int NUM_DETECTORS = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SYNC = 2'd1,
    ST_RUN       = 2'd2
  } sched_state_t;

  typedef logic [1:0] det_idx_t;

  typedef struct packed {
    det_idx_t   det;
    logic       multi;
    logic [7:0] slot;
  } slot_result_t;

  function automatic logic is_multi(input logic [NUM_DETECTORS-1:0] v);
    return (v & (v - 1'b1)) != '0;
  endfunction

  function automatic det_idx_t onehot_idx(input logic [NUM_DETECTORS-1:0] v);
    det_idx_t idx;
    idx = '0;
    for (int unsigned i = 0; i < NUM_DETECTORS; i++) begin
      if (v[i]) idx = det_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/qkd_result_fifo.sv
// Synchronous FIFO of slot results; accept/drop policy lives in the parent.
module qkd_result_fifo
  import qkd_rx_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  slot_result_t din,
  input  logic         pop,
  output slot_result_t dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  slot_result_t mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/qkd_gate_scheduler.sv
// Receiver detection-slot controller: gated click capture per slot, dead time,
// single/multi classification and a queued result stream.
module qkd_gate_scheduler
  import qkd_rx_pkg::*;
#(
  parameter int SLOT_CYCLES = 8,
  parameter int GATE_CYCLES = 2,
  parameter int DEAD_CYCLES = 16,
  parameter int FRAME_SLOTS = 256,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       sync_pulse,
  input  logic [3:0] ttl_pulses,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [1:0] res_det,
  output logic       res_multi,
  output logic [7:0] res_slot,
  output logic       frame_done,
  output logic       overflow,
  output logic       busy
);

  localparam int PW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int DW = $clog2(DEAD_CYCLES + 2);
  localparam logic [PW-1:0] PHASE_LAST = PW'(SLOT_CYCLES - 1);
  localparam logic [PW:0]   GATE_END   = (PW + 1)'(GATE_CYCLES);
  localparam logic [7:0]    SLOT_LAST  = 8'(FRAME_SLOTS - 1);
  localparam logic [DW-1:0] DEAD_LOAD  = DW'(DEAD_CYCLES);

  sched_state_t             state;
  logic [PW-1:0]            phase;
  logic [7:0]               slot;
  logic [NUM_DETECTORS-1:0] ttl_q;
  logic [NUM_DETECTORS-1:0] hits;
  logic [DW-1:0]            dead_cnt;
  logic                     enable_q;

  logic         gate_open, slot_end, push_req, push, pop, full, empty;
  slot_result_t push_res, head;

  always_comb begin
    gate_open = (state == ST_RUN) && ({1'b0, phase} < GATE_END) && (dead_cnt == '0);
    slot_end  = enable && (state == ST_RUN) && (phase == PHASE_LAST);
    push_req  = slot_end && (hits != '0);
    pop       = !empty && res_ready;
    push      = push_req && (!full || pop);
    push_res.multi = is_multi(hits);
    push_res.det   = push_res.multi ? det_idx_t'(0) : onehot_idx(hits);
    push_res.slot  = slot;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      phase      <= '0;
      slot       <= '0;
      hits       <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!enable) begin
        // Dropping enable abandons the partial slot; queued results stay.
        state <= ST_IDLE;
        phase <= '0;
        slot  <= '0;
        hits  <= '0;
      end else begin
        case (state)
          ST_IDLE: state <= ST_WAIT_SYNC;
          ST_WAIT_SYNC: begin
            if (sync_pulse) begin
              state <= ST_RUN;
              phase <= '0;
              slot  <= '0;
              hits  <= '0;
            end
          end
          ST_RUN: begin
            if (phase == PHASE_LAST) begin
              phase <= '0;
              hits  <= '0;
              if (slot == SLOT_LAST) begin
                slot       <= '0;
                state      <= ST_WAIT_SYNC;
                frame_done <= 1'b1;
              end else begin
                slot <= slot + 1'b1;
              end
            end else begin
              phase <= phase + 1'b1;
              if (gate_open) hits <= hits | ttl_q;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Dead time follows the detector click, so it arms even if the result is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ttl_q    <= '0;
      dead_cnt <= '0;
      enable_q <= 1'b0;
      overflow <= 1'b0;
    end else begin
      ttl_q    <= ttl_pulses;
      enable_q <= enable;
      if (push_req)            dead_cnt <= DEAD_LOAD;
      else if (dead_cnt != '0) dead_cnt <= dead_cnt - 1'b1;
      if (enable && !enable_q)          overflow <= 1'b0;
      else if (push_req && full && !pop) overflow <= 1'b1;
    end
  end

  qkd_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_res),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign res_valid = !empty;
  assign res_det   = empty ? 2'd0 : head.det;
  assign res_multi = empty ? 1'b0 : head.multi;
  assign res_slot  = empty ? 8'd0 : head.slot;
  assign busy      = (state != ST_IDLE);

endmodule
